// File: rtl/alu_seq_ctrl_if.sv
// Front-end bus of the ALU sequencer: request (start/op/operands) and
// completion (busy/done/result/flags). The adder port stays on the module.
interface alu_seq_ctrl_if;
   logic        start;
   logic [1:0]  op;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        flg_c;
   logic        flg_v;
   logic        flg_n;
   logic        flg_z;
   logic        div_by_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, result, flg_c, flg_v, flg_n, flg_z, div_by_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, flg_c, flg_v, flg_n, flg_z, div_by_zero
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer time-multiplexing one external 9-bit add/sub unit for ADD, SUB, Booth MUL and
// non-restoring DIV. Optional macro ALU_SAT_EN: saturate ADD/SUB results on signed overflow.
module alu_seq_ctrl #(
   parameter int unsigned WIDTH     = 8,
   parameter logic [7:0]  DIV0_QUOT = 8'hFF
) (
   input  logic             clk,
   input  logic             rst,
   alu_seq_ctrl_if.slave    fe,
   output logic [WIDTH:0]   add_x_o,
   output logic [WIDTH:0]   add_y_o,
   output logic             add_sel_o,
   input  logic [WIDTH:0]   add_z_i
);

   localparam int unsigned AW = WIDTH + 1;
   localparam int unsigned RW = 2 * WIDTH;
   localparam int unsigned CW = 3;

   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic [AW-1:0]     acc_q, acc_d, m_q, m_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic              q1_q, q1_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [AW-1:0]     add_x_q, add_x_d, add_y_q, add_y_d;
   logic              add_sel_q, add_sel_d;
   logic [RW-1:0]     res_q, res_d;
   logic              c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d, dbz_q, dbz_d;
   logic              busy_q, busy_d, done_q, done_d;

   logic [WIDTH-1:0]  sum;
   logic [WIDTH-1:0]  sat_sum;
   logic              vflag;
   logic              fin;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         m_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         cnt_q     <= '0;
         add_x_q   <= '0;
         add_y_q   <= '0;
         add_sel_q <= 1'b0;
         res_q     <= '0;
         c_q       <= 1'b0;
         v_q       <= 1'b0;
         n_q       <= 1'b0;
         z_q       <= 1'b0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         m_q       <= m_d;
         q_q       <= q_d;
         q1_q      <= q1_d;
         cnt_q     <= cnt_d;
         add_x_q   <= add_x_d;
         add_y_q   <= add_y_d;
         add_sel_q <= add_sel_d;
         res_q     <= res_d;
         c_q       <= c_d;
         v_q       <= v_d;
         n_q       <= n_d;
         z_q       <= z_d;
         dbz_q     <= dbz_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      m_d     = m_q;
      q_d     = q_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      c_d     = c_q;
      v_d     = v_q;
      n_d     = n_q;
      z_d     = z_q;
      dbz_d   = dbz_q;
      fin     = 1'b0;

      sum   = add_z_i[WIDTH-1:0];
      vflag = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ op_q[0])) && (sum[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ALU_SAT_EN
      // Overflow direction follows the sign of a: positive a can only overflow upward.
      sat_sum = vflag ? (a_q[WIDTH-1] ? 8'h80 : 8'h7F) : sum;
`else
      sat_sum = sum;
`endif

      case (state_q)
         S_IDLE: begin
            if (fe.start) begin
               op_d    = fe.op;
               a_d     = fe.a;
               b_d     = fe.b;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            acc_d   = '0;
            q1_d    = 1'b0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_ITER;
            case (op_q)
               OP_MUL: begin
                  q_d = b_q;
                  m_d = {a_q[WIDTH-1], a_q};
               end
               OP_DIV: begin
                  q_d = a_q;
                  m_d = {1'b0, b_q};
                  if (b_q == '0) begin
                     state_d = S_DONE;
                     fin     = 1'b1;
                     res_d   = {a_q, DIV0_QUOT};
                     c_d     = 1'b0;
                     v_d     = 1'b0;
                     n_d     = 1'b0;
                     dbz_d   = 1'b1;
                  end
               end
               default: cnt_d = '0;
            endcase
         end
         S_ITER: begin
            cnt_d = cnt_q - CW'(1);
            case (op_q)
               OP_MUL: begin
                  // Arithmetic shift right of {A,Q,q_1} applied to the fresh adder sum.
                  acc_d = {add_z_i[AW-1], add_z_i[AW-1:1]};
                  q_d   = {add_z_i[0], q_q[WIDTH-1:1]};
                  q1_d  = q_q[0];
                  if (cnt_q == '0) begin
                     state_d = S_DONE;
                     fin     = 1'b1;
                     res_d   = {acc_d[WIDTH-1:0], q_d};
                     c_d     = 1'b0;
                     v_d     = 1'b0;
                     n_d     = res_d[RW-1];
                     dbz_d   = 1'b0;
                  end
               end
               OP_DIV: begin
                  acc_d = add_z_i;
                  q_d   = {q_q[WIDTH-2:0], ~add_z_i[AW-1]};
                  if (cnt_q == '0) begin
                     state_d = S_FIX;
                  end
               end
               default: begin
                  state_d = S_DONE;
                  fin     = 1'b1;
                  res_d   = {8'h00, sat_sum};
                  c_d     = add_z_i[WIDTH];
                  v_d     = vflag;
                  n_d     = sat_sum[WIDTH-1];
                  dbz_d   = 1'b0;
               end
            endcase
         end
         S_FIX: begin
            acc_d   = add_z_i;
            state_d = S_DONE;
            fin     = 1'b1;
            res_d   = {acc_d[WIDTH-1:0], q_q};
            c_d     = 1'b0;
            v_d     = 1'b0;
            n_d     = 1'b0;
            dbz_d   = 1'b0;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (fin) begin
         z_d = (res_d == '0);
      end
   end

   // Adder operands for the cycle being entered, derived from the post-update datapath.
   always_comb begin
      add_x_d   = '0;
      add_y_d   = '0;
      add_sel_d = 1'b0;
      if (state_d == S_ITER) begin
         case (op_q)
            OP_MUL: begin
               add_x_d   = acc_d;
               add_y_d   = (q_d[0] ^ q1_d) ? m_d : '0;
               add_sel_d = q_d[0] & ~q1_d;
            end
            OP_DIV: begin
               add_x_d   = {acc_d[WIDTH-1:0], q_d[WIDTH-1]};
               add_y_d   = m_d;
               add_sel_d = ~acc_d[AW-1];
            end
            default: begin
               add_x_d   = {1'b0, a_q};
               add_y_d   = {1'b0, b_q};
               add_sel_d = op_q[0];
            end
         endcase
      end else if (state_d == S_FIX) begin
         add_x_d = acc_d;
         add_y_d = acc_d[AW-1] ? m_d : '0;
      end
      busy_d = (state_d == S_LOAD) || (state_d == S_ITER) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   assign fe.busy        = busy_q;
   assign fe.done        = done_q;
   assign fe.result      = res_q;
   assign fe.flg_c       = c_q;
   assign fe.flg_v       = v_q;
   assign fe.flg_n       = n_q;
   assign fe.flg_z       = z_q;
   assign fe.div_by_zero = dbz_q;
   assign add_x_o        = add_x_q;
   assign add_y_o        = add_y_q;
   assign add_sel_o      = add_sel_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: arithmetic reference model with per-cycle compare, plus directed
// vectors carrying hand-computed results, flags and latencies.
module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [8:0] add_x, add_y, add_z;
   logic       add_sel;

   always #5 clk = ~clk;

   alu_seq_ctrl_if fe ();

   alu_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .fe        (fe),
      .add_x_o   (add_x),
      .add_y_o   (add_y),
      .add_sel_o (add_sel),
      .add_z_i   (add_z)
   );

   // Behavioural stand-in for the external 9-bit adder.
   assign add_z = add_sel ? (add_x - add_y) : (add_x + add_y);

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [15:0] res;
      logic        c, v, n, z, dbz;
   } out_t;

   function automatic out_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output int lat);
      out_t o;
      int   ua, ub, sa, sb, s, p;
      logic [7:0] sm;
      o  = '0;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         2'b00, 2'b01: begin
            s     = (op == 2'b00) ? sa + sb : sa - sb;
            o.c   = (op == 2'b00) ? (ua + ub > 255) : (ua < ub);
            o.v   = (s > 127) || (s < -128);
            sm    = 8'(s);
`ifdef ALU_SAT_EN
            if (o.v) sm = (s > 127) ? 8'h7F : 8'h80;
`endif
            o.res = {8'h00, sm};
            o.n   = sm[7];
            lat   = 3;
         end
         2'b10: begin
            p     = sa * sb;
            o.res = 16'(p);
            o.n   = o.res[15];
            lat   = 10;
         end
         default: begin
            if (ub == 0) begin
               o.res = {a, 8'hFF};
               o.dbz = 1'b1;
               lat   = 2;
            end else begin
               o.res = {8'(ua % ub), 8'(ua / ub)};
               lat   = 11;
            end
         end
      endcase
      o.z = (o.res == 16'h0000);
      return o;
   endfunction

   // Model timeline: t counts cycles since acceptance, done expected at t == lat.
   int   t     = 0;
   int   lat   = 0;
   bit   armed = 1'b0;
   out_t exp_o = '0;
   out_t pend_o = '0;

   always @(posedge clk) begin
      if (rst) begin
         t     = 0;
         lat   = 0;
         exp_o = '0;
         armed = 1'b1;
      end else if (t == 0) begin
         if (fe.start) begin
            pend_o = model(fe.op, fe.a, fe.b, lat);
            t      = 1;
         end
      end else if (t == lat) begin
         t = 0;
      end else begin
         t++;
         if (t == lat) exp_o = pend_o;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("busy", 32'(fe.busy), 32'((t >= 1) && (t < lat)));
         chk("done", 32'(fe.done), 32'((t != 0) && (t == lat)));
         chk("result", 32'(fe.result), 32'(exp_o.res));
         chk("flags", 32'({fe.flg_c, fe.flg_v, fe.flg_n, fe.flg_z, fe.div_by_zero}),
             32'({exp_o.c, exp_o.v, exp_o.n, exp_o.z, exp_o.dbz}));
      end
   end

   // One operation with literal expectations; poke pulses a stray start mid-operation.
   task automatic run(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] er, input logic [4:0] ef, input int el, input bit poke);
      int k;
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      fe.start = 1'b1;
      fe.op    = op;
      fe.a     = a;
      fe.b     = b;
      @(negedge clk);
      fe.start = 1'b0;
      k = 1;
      while (k <= 20) begin
         if (fe.done) begin
            seen = 1'b1;
            break;
         end
         if (poke && k == 4) begin
            fe.start = 1'b1;
            fe.op    = 2'b00;
            fe.a     = ~a;
            fe.b     = ~b;
         end else begin
            fe.start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      fe.start = 1'b0;
      chk("latency", seen ? 32'(k) : 32'hFFFF, 32'(el));
      chk("lit_result", 32'(fe.result), 32'(er));
      chk("lit_flags", 32'({fe.flg_c, fe.flg_v, fe.flg_n, fe.flg_z, fe.div_by_zero}), 32'(ef));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      fe.start = 1'b0;
      fe.op    = 2'b00;
      fe.a     = 8'h00;
      fe.b     = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_result", 32'(fe.result), 32'h0);
      chk("rst_busy_done", 32'({fe.busy, fe.done}), 32'h0);
      chk("rst_adder", 32'({add_x, add_y, add_sel}), 32'h0);
      chk("rst_flags", 32'({fe.flg_c, fe.flg_v, fe.flg_n, fe.flg_z, fe.div_by_zero}), 32'h0);
      rst = 1'b0;

      // Flags literal order: {c, v, n, z, div_by_zero}.
      run(2'b00, 8'h4F, 8'h30, 16'h007F, 5'b00000, 3, 1'b0);
`ifdef ALU_SAT_EN
      run(2'b00, 8'h7F, 8'h01, 16'h007F, 5'b01000, 3, 1'b0);
      run(2'b00, 8'h80, 8'h80, 16'h0080, 5'b11100, 3, 1'b0);
      run(2'b01, 8'h80, 8'h01, 16'h0080, 5'b01100, 3, 1'b0);
`else
      run(2'b00, 8'h7F, 8'h01, 16'h0080, 5'b01100, 3, 1'b0);
      run(2'b00, 8'h80, 8'h80, 16'h0000, 5'b11010, 3, 1'b0);
      run(2'b01, 8'h80, 8'h01, 16'h007F, 5'b01000, 3, 1'b0);
`endif
      run(2'b00, 8'hFF, 8'h01, 16'h0000, 5'b10010, 3, 1'b0);
      run(2'b01, 8'h08, 8'h10, 16'h00F8, 5'b10100, 3, 1'b0);
      run(2'b01, 8'h20, 8'h20, 16'h0000, 5'b00010, 3, 1'b0);
      run(2'b10, 8'hFD, 8'h07, 16'hFFEB, 5'b00100, 10, 1'b0);
      run(2'b10, 8'h80, 8'h80, 16'h4000, 5'b00000, 10, 1'b0);
      run(2'b10, 8'h7F, 8'h81, 16'hC0FF, 5'b00100, 10, 1'b1);
      run(2'b10, 8'h00, 8'h55, 16'h0000, 5'b00010, 10, 1'b0);
      run(2'b10, 8'hFF, 8'hFF, 16'h0001, 5'b00000, 10, 1'b0);
      run(2'b11, 8'd200, 8'd7, 16'h041C, 5'b00000, 11, 1'b0);
      run(2'b11, 8'h05, 8'h00, 16'h05FF, 5'b00001, 2, 1'b0);
      run(2'b11, 8'hFF, 8'h01, 16'h00FF, 5'b00000, 11, 1'b0);
      run(2'b11, 8'h03, 8'hC8, 16'h0300, 5'b00000, 11, 1'b0);
      run(2'b11, 8'hFF, 8'hFF, 16'h0001, 5'b00000, 11, 1'b0);
      run(2'b11, 8'h00, 8'h00, 16'h00FF, 5'b00001, 2, 1'b0);

      // Abort a division part-way through.
      @(negedge clk);
      fe.start = 1'b1;
      fe.op    = 2'b11;
      fe.a     = 8'd200;
      fe.b     = 8'd7;
      @(negedge clk);
      fe.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(fe.busy), 32'h0);
      chk("abort_result", 32'(fe.result), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(fe.done), 32'h0);
      end

      run(2'b00, 8'h12, 8'h34, 16'h0046, 5'b00000, 3, 1'b0);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
